// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolution-side partner of the 2-bit branch direction predictor. Every
// prediction made at fetch is queued in order. The oldest entry is matched
// against the outcome resolved in MEM, which drives the predictor update
// port. A misprediction registers a redirect, clears the in-flight queue
// and holds a flush for FLUSH_CYCLES cycles.

module branch_resolve_unit #(
    parameter int DEPTH        = 4,   // power of two, >= 2
    parameter int FLUSH_CYCLES = 2    // >= 1
) (
    input  logic                         clk,
    input  logic                         rst,              // synchronous, active-low

    // fetch-side push of a new prediction
    input  logic                         f_valid,
    input  logic [31:0]                  f_pc,
    input  logic                         f_pred_dir,
    input  logic [31:0]                  f_pred_target,
    output logic                         f_ready,

    // MEM-side resolution of the oldest in-flight branch
    input  logic                         r_valid,
    input  logic                         r_taken,
    input  logic [31:0]                  r_target,

    // predictor update port
    output logic                         upd_valid,
    output logic [31:0]                  upd_pc,
    output logic                         upd_taken,

    // recovery
    output logic                         redirect_valid,
    output logic [31:0]                  redirect_pc,
    output logic                         flush,

    // status
    output logic [15:0]                  mispredict_count,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic                         err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES+1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_dir;
        logic [31:0] pred_target;
    } entry_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [FC_W-1:0]       r_flush_cnt;
    logic [FC_W-1:0]       w_flush_cnt_next;

    entry_t                r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  r_upd_valid;
    logic [31:0]           r_upd_pc;
    logic                  r_upd_taken;
    logic                  r_redirect_valid;
    logic [31:0]           r_redirect_pc;
    logic                  r_flush;
    logic [15:0]           r_mispredict_count;
    logic                  r_err;

    // ------------------------------------------------------------------
    // Combinational decode of this cycle's events
    // ------------------------------------------------------------------
    entry_t                w_head;
    entry_t                w_push_entry;
    logic                  w_run;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_mispredict;
    logic                  w_empty_resolve;
    logic [31:0]           w_correct_pc;

    assign w_run   = (r_state == ST_RUN);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    assign w_push_entry = '{pc: f_pc, pred_dir: f_pred_dir, pred_target: f_pred_target};

    // Ready depends only on registered state, never on r_valid, so fetch
    // sees a stable handshake early in the cycle.
    assign f_ready = w_run && !w_full;

    assign w_pop           = r_valid && w_run && !w_empty;
    assign w_empty_resolve = r_valid && w_run && w_empty;

    assign w_mispredict = w_pop &&
                          ((w_head.pred_dir != r_taken) ||
                           (w_head.pred_dir && r_taken && (w_head.pred_target != r_target)));

    // A push racing a mispredict belongs to the wrong path and is dropped.
    assign w_push = f_valid && f_ready && !w_mispredict;

    assign w_correct_pc = r_taken ? r_target : (w_head.pc + 32'd4);

    // ------------------------------------------------------------------
    // FSM: next-state and flush-counter logic
    // ------------------------------------------------------------------
    // Select the next state and flush countdown value from the current state.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mispredict) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = FC_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                w_flush_cnt_next = r_flush_cnt - FC_W'(1);
                if (r_flush_cnt == FC_W'(1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next     = ST_RUN;
                w_flush_cnt_next = '0;
            end
        endcase
    end

    // Register the FSM state and the flush countdown.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // In-flight queue
    // ------------------------------------------------------------------
    // Write accepted predictions into the circular buffer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only read once
        // the occupancy count says they were written, so clearing them
        // would just cost reset fan-out.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Advance pointers and occupancy; a mispredict empties the queue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispredict) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign inflight = r_count;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    // Predictor update: one strobe per pop, one cycle after resolution.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_taken <= 1'b0;
        end else begin
            r_upd_valid <= w_pop;
            if (w_pop) begin
                r_upd_pc    <= w_head.pc;
                r_upd_taken <= r_taken;
            end
        end
    end

    // Redirect pulse and flush window following a mispredict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_correct_pc;
            end
            r_flush <= (w_state_next == ST_FLUSH);
        end
    end

    // Saturating mispredict counter and sticky empty-resolve error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mispredict_count <= '0;
            r_err              <= 1'b0;
        end else begin
            if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
            if (w_empty_resolve) begin
                r_err <= 1'b1;
            end
        end
    end

    assign upd_valid        = r_upd_valid;
    assign upd_pc           = r_upd_pc;
    assign upd_taken        = r_upd_taken;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign flush            = r_flush;
    assign mispredict_count = r_mispredict_count;
    assign err              = r_err;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side partner of the 2-bit branch direction predictor. It records every prediction made at fetch in an in-order in-flight queue, matches it against the resolved outcome from the MEM stage, and drives the predictor update port (valid/PC/outcome). On a misprediction it issues a PC redirect and a timed pipeline flush.

## Interface
- DEPTH, 4: maximum in-flight predicted branches; power of two, ≥2.
- FLUSH_CYCLES, 2: cycles `flush` stays high after a mispredict; ≥1.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- f_valid  in  1  fetch pushes a branch prediction
- f_pc  in  32  PC of the fetched branch
- f_pred_dir  in  1  predicted direction (1 = taken)
- f_pred_target  in  32  target fetched from if predicted taken
- f_ready  out  1  push accepted; fetch stalls when low
- r_valid  in  1  oldest in-flight branch resolved this cycle
- r_taken  in  1  actual direction
- r_target  in  32  actual taken target
- upd_valid  out  1  predictor update strobe
- upd_pc  out  32  PC of the branch being updated
- upd_taken  out  1  actual outcome for the predictor
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  corrected fetch PC
- flush  out  1  kill younger pipeline stages
- mispredict_count  out  16  saturating mispredict counter
- inflight  out  $clog2(DEPTH+1)  current queue occupancy
- err  out  1  sticky: `r_valid` arrived while the queue was empty

## Operation
- The queue is a circular FIFO of {pc, pred_dir, pred_target}. It has DEPTH entries with wrapping read/write pointers and an occupancy count.
- f_ready = (state==RUN) && (inflight != DEPTH). This is combinational and does not depend on `r_valid`.
- A push occurs when f_valid && f_ready. A pop occurs when r_valid && state==RUN && inflight != 0.
- A push and a pop in the same RUN cycle are both performed, leaving occupancy unchanged.
- Mispredict condition for the popped head:
  - (pred_dir != r_taken), or
  - (pred_dir && r_taken && pred_target != r_target).
- Correct PC = r_taken ? r_target : head.pc + 32'd4. The add is 32-bit modulo.
- Every pop produces an update on the next cycle: upd_valid=1, upd_pc=head.pc, upd_taken=r_taken.
- States:
  - RUN → FLUSH on a popped mispredict. The flush counter loads FLUSH_CYCLES.
  - FLUSH counts down each cycle. FLUSH → RUN after FLUSH_CYCLES cycles.
- Mispredict cycle effects:
  - The whole queue is cleared (pointers and count set to 0).
  - Any same-cycle push is dropped as wrong-path.
  - redirect_valid/redirect_pc are registered for the next cycle.
  - mispredict_count increments, saturating at 16'hFFFF.
- In FLUSH: `r_valid` is ignored (wrong-path), there are no pushes, upd_valid=0, and `err` is not set.
- r_valid in RUN with an empty queue: no pop, no update, and err becomes 1. err stays 1 until reset.
- Reset, including mid-flush:
  - state=RUN, queue empty, flush counter 0.
  - All outputs 0 except f_ready=1.

## Timing
- Update latency: 1 cycle. An `r_valid` in cycle N gives upd_valid high in cycle N+1 only.
- Redirect: redirect_valid is high in cycle N+1 for exactly one cycle, with redirect_pc valid in the same cycle.
- Flush: high in cycles N+1 through N+FLUSH_CYCLES.
- f_ready: low in cycles N+1 through N+FLUSH_CYCLES. It returns high in cycle N+FLUSH_CYCLES+1.
- Counter: mispredict_count reflects the increment in cycle N+1.
- Correct prediction: upd_valid pulses in N+1. No redirect, no flush, and the queue keeps its younger entries.
- Back-to-back resolutions in RUN each produce one update pulse per cycle.
- Outputs are all registered except f_ready and inflight, which are derived from state and count registers.

## Test plan
- **Reset:** hold rst=0 for 2 cycles, then release → f_ready=1, inflight=0, flush=0, upd_valid=0, redirect_valid=0, mispredict_count=0, err=0.
- **Correct not-taken:**
  - Stimulus: push pc=0x100, pred_dir=0, then resolve r_taken=0.
  - Response: one cycle later upd_valid=1, upd_pc=0x100, upd_taken=0, no redirect, inflight=0.
- **Direction mispredict:**
  - Stimulus: push pc=0x200, pred_dir=0, plus younger 0x204. Resolve r_taken=1, r_target=0x400.
  - Response: next cycle redirect_valid=1, redirect_pc=0x400, upd_taken=1. flush high for 2 cycles, inflight=0, mispredict_count=1.
- **Target mispredict / wrap:**
  - Stimulus: fill 4 entries so f_ready=0. Pop 2, push 2 to wrap the pointers. Resolve the head, which has pred_dir=1, pred_target=0x300, with r_taken=1, r_target=0x310.
  - Response: redirect_pc=0x310. A same-cycle push is dropped.
- **Predicted taken, actually not taken:** pc=0xFFFFFFFC → redirect_pc=0x00000000 (wrap).
- **Empty and mid-flush events:**
  - r_valid on an empty queue → err=1, no upd_valid.
  - r_valid during FLUSH → ignored.
  - rst=0 mid-flush → flush=0 next cycle, f_ready=1.
